// File: rtl/line_buffer_3x.sv
// Sliding column-vector line buffer: emits the current pixel plus the same column
// from the previous M_DEPTH-1 lines, two cycles after input, with top-edge zero padding.
module line_buffer_3x #(
    parameter int COLORDEPTH = 8,
    parameter int M_DEPTH    = 3,
    parameter int MAX_WIDTH  = 2048,
    parameter int ADDR_W     = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [COLORDEPTH-1:0] px_i,
    input  logic                  dv_i,
    input  logic                  hs_i,
    input  logic                  vs_i,
    output logic [COLORDEPTH-1:0] vect_o [M_DEPTH-1:0],
    output logic                  dv_o,
    output logic                  hs_o,
    output logic                  vs_o,
    output logic                  rows_ok_o,
    output logic                  ovf_o
);

    localparam int                  LINES_W   = (M_DEPTH > 2) ? $clog2(M_DEPTH) : 1;
    localparam logic [ADDR_W:0]     COL_MAX   = (ADDR_W + 1)'(MAX_WIDTH);
    localparam logic [LINES_W-1:0]  LINES_MAX = LINES_W'(M_DEPTH - 1);

    logic [ADDR_W:0]         r_col;
    logic [LINES_W-1:0]      r_lines;
    logic                    r_dv_d;
    logic                    r_vs_d;
    logic                    r_ovf;

    logic [COLORDEPTH-1:0]   r_px_s1;
    logic                    r_we_s1;
    logic [ADDR_W-1:0]       r_addr_s1;
    logic [LINES_W-1:0]      r_lines_s1;
    logic                    r_hs_s1;
    logic                    r_vs_s1;

    logic [COLORDEPTH-1:0]   r_vect [M_DEPTH];
    logic                    r_dv_o;
    logic                    r_hs_o;
    logic                    r_vs_o;
    logic                    r_ok_o;

    logic [COLORDEPTH-1:0]   w_rd [M_DEPTH-1];
    logic                    w_dv_fall;
    logic                    w_vs_rise;
    logic                    w_col_full;
    logic                    w_we;
    logic [ADDR_W-1:0]       w_addr;
    logic [LINES_W-1:0]      w_lines_eff;

    assign w_dv_fall   = r_dv_d & ~dv_i;
    assign w_vs_rise   = vs_i & ~r_vs_d;
    assign w_col_full  = (r_col >= COL_MAX);
    // A vsync pixel always lands at column 0 of a fresh frame, so it is never dropped.
    assign w_we        = dv_i & (vs_i | ~w_col_full);
    assign w_addr      = vs_i ? '0 : r_col[ADDR_W-1:0];
    assign w_lines_eff = vs_i ? '0 : r_lines;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col   <= '0;
            r_lines <= '0;
            r_dv_d  <= 1'b0;
            r_vs_d  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_dv_d <= dv_i;
            r_vs_d <= vs_i;
            if (vs_i) begin
                r_col   <= '0;
                r_lines <= '0;
            end else if (w_dv_fall) begin
                r_col <= '0;
                if (r_lines != LINES_MAX) begin
                    r_lines <= r_lines + 1'b1;
                end
            end else if (dv_i && !w_col_full) begin
                r_col <= r_col + 1'b1;
            end
            if (w_vs_rise) begin
                r_ovf <= 1'b0;
            end else if (dv_i && !vs_i && w_col_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_px_s1    <= '0;
            r_we_s1    <= 1'b0;
            r_addr_s1  <= '0;
            r_lines_s1 <= '0;
            r_hs_s1    <= 1'b0;
            r_vs_s1    <= 1'b0;
        end else begin
            r_we_s1 <= w_we;
            r_hs_s1 <= hs_i;
            r_vs_s1 <= vs_i;
            if (w_we) begin
                r_px_s1    <= px_i;
                r_addr_s1  <= w_addr;
                r_lines_s1 <= w_lines_eff;
            end
        end
    end

    // Each memory is written one cycle after its read with the data that read returned,
    // so memory k always holds the line that memory k-1 held before it.
    genvar gi;
    generate
        for (gi = 0; gi < M_DEPTH - 1; gi++) begin : g_line
            logic [COLORDEPTH-1:0] r_mem [MAX_WIDTH];
            logic [COLORDEPTH-1:0] r_rd;
            logic [COLORDEPTH-1:0] w_wr_data;

            if (gi == 0) begin : g_head
                assign w_wr_data = r_px_s1;
            end else begin : g_tail
                assign w_wr_data = w_rd[gi-1];
            end

            always_ff @(posedge clk) begin
                if (r_we_s1) begin
                    r_mem[r_addr_s1] <= w_wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_rd <= '0;
                end else if (w_we) begin
                    r_rd <= r_mem[w_addr];
                end
            end

            assign w_rd[gi] = r_rd;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < M_DEPTH; k++) begin
                r_vect[k] <= '0;
            end
            r_dv_o <= 1'b0;
            r_hs_o <= 1'b0;
            r_vs_o <= 1'b0;
            r_ok_o <= 1'b0;
        end else begin
            r_dv_o <= r_we_s1;
            r_hs_o <= r_hs_s1;
            r_vs_o <= r_vs_s1;
            r_ok_o <= r_we_s1 && (r_lines_s1 == LINES_MAX);
            if (r_we_s1) begin
                r_vect[0] <= r_px_s1;
                for (int k = 1; k < M_DEPTH; k++) begin
                    r_vect[k] <= (r_lines_s1 < LINES_W'(k)) ? '0 : w_rd[k-1];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < M_DEPTH; gi++) begin : g_out
            assign vect_o[gi] = r_vect[gi];
        end
    endgenerate

    assign dv_o      = r_dv_o;
    assign hs_o      = r_hs_o;
    assign vs_o      = r_vs_o;
    assign rows_ok_o = r_ok_o;
    assign ovf_o     = r_ovf;

endmodule
